// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller.
// Contents: opcode/funct constants of the supported MIPS subset, the FSM
// state type, the exception sub-phase type and the encodings of every
// datapath mux select driven by the controller.
package ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] NULL  = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] BNE   = 6'h05;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] ADDIU = 6'h09;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2b;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] ADD  = 6'h20;
  localparam logic [5:0] SUB  = 6'h22;
  localparam logic [5:0] AND  = 6'h24;
  localparam logic [5:0] MULT = 6'h18;
  localparam logic [5:0] DIV  = 6'h1a;

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_IR_LOAD, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_BRANCH, S_JUMP, S_MEM_ADDR, S_MEM_WR, S_MEM_RD, S_MEM_WB, S_LW_WB,
    S_MD_START, S_MD_WAIT, S_EXC
  } state_t;

  // Sub-steps of the exception sequence: save EPC, read vector, latch MDR, jump
  typedef enum logic [1:0] {EX_EPC, EX_VEC, EX_MDR, EX_PC} exc_phase_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;

  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_ALUOUT = 2'b01;
  localparam logic [1:0] IORD_EXC    = 2'b11;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [2:0] PCS_ALU    = 3'd0;
  localparam logic [2:0] PCS_ALUOUT = 3'd1;
  localparam logic [2:0] PCS_JUMP   = 3'd2;
  localparam logic [2:0] PCS_EXC    = 3'd3;

  localparam logic [1:0] EXC_ILLEGAL = 2'b00;
  localparam logic [1:0] EXC_OVF     = 2'b01;
  localparam logic [1:0] EXC_DIV0    = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;

  localparam logic [2:0] M2R_ALUOUT = 3'd0;
  localparam logic [2:0] M2R_MDR    = 3'd1;

  // ALU operation for the R-type arithmetic group
  function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
    case (funct)
      SUB:     return ALU_SUB;
      AND:     return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_unit_mc_if.sv
// Controller <-> datapath bundle.
// master: the controller (consumes ALU/mult-div flags and IR fields,
//         drives every write enable and mux select).
// slave : the datapath side (the mirror image).
interface ctrl_unit_mc_if;
  // datapath -> controller
  logic       Overflow;
  logic       EQ;
  logic       ErroDiv;
  logic       md_done;
  logic [5:0] OPCODE;
  logic [5:0] FUNCT;
  // controller -> datapath
  logic       PCWrite, MemWrite, IRWrite, BRWrite, ABWrite;
  logic       EPCWrite, HIWrite, LOWrite, MDRWrite, ALUOutWrite;
  logic       md_start;
  logic       MultOrDiv;
  logic [2:0] ALUOp;
  logic [1:0] IorD;
  logic [1:0] RegDst;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] Exception;
  logic [2:0] MemToReg;
  logic [2:0] PCSource;
  logic       rst_out;
  logic [4:0] state_dbg;

  modport master (
    input  Overflow, EQ, ErroDiv, md_done, OPCODE, FUNCT,
    output PCWrite, MemWrite, IRWrite, BRWrite, ABWrite, EPCWrite, HIWrite,
           LOWrite, MDRWrite, ALUOutWrite, md_start, MultOrDiv, ALUOp, IorD,
           RegDst, ALUSrcA, ALUSrcB, Exception, MemToReg, PCSource, rst_out,
           state_dbg
  );

  modport slave (
    output Overflow, EQ, ErroDiv, md_done, OPCODE, FUNCT,
    input  PCWrite, MemWrite, IRWrite, BRWrite, ABWrite, EPCWrite, HIWrite,
           LOWrite, MDRWrite, ALUOutWrite, md_start, MultOrDiv, ALUOp, IorD,
           RegDst, ALUSrcA, ALUSrcB, Exception, MemToReg, PCSource, rst_out,
           state_dbg
  );
endinterface

// File: rtl/ctrl_dispatch.sv
// Instruction dispatch decode, consulted only in DECODE.
// Ports: opcode, funct (IR fields) in; target (state to enter after
// DECODE) and legal (0 = unsupported encoding, take illegal-opcode trap) out.
module ctrl_dispatch
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     target,
  output logic       legal
);

  always_comb begin
    target = S_EXC;
    legal  = 1'b1;
    case (opcode)
      NULL: begin
        case (funct)
          ADD, SUB, AND: target = S_EXEC_R;
          MULT, DIV:     target = S_MD_START;
          default:       legal  = 1'b0;
        endcase
      end
      ADDI, ADDIU: target = S_EXEC_I;
      BEQ, BNE:    target = S_BRANCH;
      J:           target = S_JUMP;
      LW, SW:      target = S_MEM_ADDR;
      default:     legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_mc.sv
// Multicycle MIPS-subset controller (Moore FSM).
// Ports: clk, reset (synchronous, active-low), bus (ctrl_unit_mc_if.master:
// ALU/mult-div flags and IR fields in, all datapath enables/selects out).
// MEM_LAT sets the memory wait for instruction fetch, load data and the
// exception vector read; CNT_W must satisfy 2**CNT_W > MEM_LAT.
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 3
) (
  input  logic           clk,
  input  logic           reset,
  ctrl_unit_mc_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t           state_reg, state_next;
  exc_phase_t       phase_reg, phase_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       exc_code_reg, exc_code_next;
  logic             md_div_reg, md_div_next;

  state_t disp_target;
  logic   disp_legal;

  ctrl_dispatch u_dispatch (
    .opcode (bus.OPCODE),
    .funct  (bus.FUNCT),
    .target (disp_target),
    .legal  (disp_legal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= S_RST;
      phase_reg    <= EX_EPC;
      cnt_reg      <= '0;
      exc_code_reg <= EXC_ILLEGAL;
      md_div_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      cnt_reg      <= cnt_next;
      exc_code_reg <= exc_code_next;
      md_div_reg   <= md_div_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    exc_code_next = exc_code_reg;
    md_div_next   = md_div_reg;

    bus.PCWrite     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.BRWrite     = 1'b0;
    bus.ABWrite     = 1'b0;
    bus.EPCWrite    = 1'b0;
    bus.HIWrite     = 1'b0;
    bus.LOWrite     = 1'b0;
    bus.MDRWrite    = 1'b0;
    bus.ALUOutWrite = 1'b0;
    bus.md_start    = 1'b0;
    bus.MultOrDiv   = 1'b0;
    bus.ALUOp       = ALU_PASS;
    bus.IorD        = IORD_PC;
    bus.RegDst      = REGDST_RT;
    bus.ALUSrcA     = SRCA_PC;
    bus.ALUSrcB     = SRCB_B;
    bus.Exception   = EXC_ILLEGAL;
    bus.MemToReg    = M2R_ALUOUT;
    bus.PCSource    = PCS_ALU;
    bus.rst_out     = 1'b0;

    case (state_reg)
      S_RST: begin
        bus.rst_out = 1'b1;
        state_next  = S_FETCH;
      end
      S_FETCH: begin
        bus.IorD    = IORD_PC;
        bus.ALUSrcA = SRCA_PC;
        bus.ALUSrcB = SRCB_4;
        bus.ALUOp   = ALU_ADD;
        if (cnt_reg == CNT_LAST) state_next = S_IR_LOAD;
      end
      S_IR_LOAD: begin
        bus.PCWrite  = 1'b1;
        bus.IRWrite  = 1'b1;
        bus.PCSource = PCS_ALU;
        bus.ALUSrcA  = SRCA_PC;
        bus.ALUSrcB  = SRCB_4;
        bus.ALUOp    = ALU_ADD;
        state_next   = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures the branch target speculatively
        bus.ABWrite     = 1'b1;
        bus.ALUSrcA     = SRCA_PC;
        bus.ALUSrcB     = SRCB_IMM_SH;
        bus.ALUOp       = ALU_ADD;
        bus.ALUOutWrite = 1'b1;
        if (disp_legal) begin
          state_next = disp_target;
        end else begin
          state_next    = S_EXC;
          exc_code_next = EXC_ILLEGAL;
        end
      end
      S_EXEC_R: begin
        bus.ALUSrcA     = SRCA_A;
        bus.ALUSrcB     = SRCB_B;
        bus.ALUOp       = funct_alu_op(bus.FUNCT);
        bus.ALUOutWrite = 1'b1;
        if (bus.Overflow && (bus.FUNCT == ADD || bus.FUNCT == SUB)) begin
          state_next    = S_EXC;
          exc_code_next = EXC_OVF;
        end else begin
          state_next = S_WB_R;
        end
      end
      S_WB_R: begin
        bus.BRWrite  = 1'b1;
        bus.RegDst   = REGDST_RD;
        bus.MemToReg = M2R_ALUOUT;
        state_next   = S_FETCH;
      end
      S_EXEC_I: begin
        bus.ALUSrcA     = SRCA_A;
        bus.ALUSrcB     = SRCB_IMM;
        bus.ALUOp       = ALU_ADD;
        bus.ALUOutWrite = 1'b1;
        // ADDIU never traps
        if (bus.Overflow && bus.OPCODE == ADDI) begin
          state_next    = S_EXC;
          exc_code_next = EXC_OVF;
        end else begin
          state_next = S_WB_I;
        end
      end
      S_WB_I: begin
        bus.BRWrite  = 1'b1;
        bus.RegDst   = REGDST_RT;
        bus.MemToReg = M2R_ALUOUT;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA  = SRCA_A;
        bus.ALUSrcB  = SRCB_B;
        bus.ALUOp    = ALU_SUB;
        bus.PCSource = PCS_ALUOUT;
        bus.PCWrite  = (bus.OPCODE == BNE) ? !bus.EQ : bus.EQ;
        state_next   = S_FETCH;
      end
      S_JUMP: begin
        bus.PCSource = PCS_JUMP;
        bus.PCWrite  = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA     = SRCA_A;
        bus.ALUSrcB     = SRCB_IMM;
        bus.ALUOp       = ALU_ADD;
        bus.ALUOutWrite = 1'b1;
        state_next      = (bus.OPCODE == SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_WR: begin
        bus.IorD     = IORD_ALUOUT;
        bus.MemWrite = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEM_RD: begin
        bus.IorD = IORD_ALUOUT;
        if (cnt_reg == CNT_LAST) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.MDRWrite = 1'b1;
        state_next   = S_LW_WB;
      end
      S_LW_WB: begin
        bus.BRWrite  = 1'b1;
        bus.RegDst   = REGDST_RT;
        bus.MemToReg = M2R_MDR;
        state_next   = S_FETCH;
      end
      S_MD_START: begin
        bus.md_start  = 1'b1;
        bus.MultOrDiv = (bus.FUNCT == DIV);
        md_div_next   = (bus.FUNCT == DIV);
        state_next    = S_MD_WAIT;
      end
      S_MD_WAIT: begin
        bus.MultOrDiv = md_div_reg;
        // ErroDiv is only meaningful together with md_done
        if (bus.md_done) begin
          if (md_div_reg && bus.ErroDiv) begin
            state_next    = S_EXC;
            exc_code_next = EXC_DIV0;
          end else begin
            bus.HIWrite = 1'b1;
            bus.LOWrite = 1'b1;
            state_next  = S_FETCH;
          end
        end
      end
      S_EXC: begin
        bus.Exception = exc_code_reg;
        case (phase_reg)
          EX_EPC: begin
            // PC was already advanced by 4 in IR_LOAD; EPC = PC - 4
            bus.ALUSrcA  = SRCA_PC;
            bus.ALUSrcB  = SRCB_4;
            bus.ALUOp    = ALU_SUB;
            bus.EPCWrite = 1'b1;
            phase_next   = EX_VEC;
          end
          EX_VEC: begin
            bus.IorD = IORD_EXC;
            if (cnt_reg == CNT_LAST) phase_next = EX_MDR;
          end
          EX_MDR: begin
            bus.MDRWrite = 1'b1;
            phase_next   = EX_PC;
          end
          default: begin
            bus.PCSource = PCS_EXC;
            bus.PCWrite  = 1'b1;
            phase_next   = EX_EPC;
            state_next   = S_FETCH;
          end
        endcase
      end
      default: state_next = S_RST;
    endcase

    // Counter restarts on any state or exception sub-phase change
    if (state_next != state_reg || phase_next != phase_reg) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    bus.state_dbg = state_reg;
  end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
module tb_ctrl_unit_mc;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_MULT = 6'h18, FN_DIV = 6'h1a;
  localparam logic [4:0] ST_RST = 5'(ctrl_pkg::S_RST);
  localparam logic [4:0] ST_FETCH = 5'(ctrl_pkg::S_FETCH);

  typedef struct packed {
    logic pcw, memw, irw, brw, abw, epcw, hiw, low, mdrw, aluow, mds, mod;
    logic [2:0] aluop;
    logic [1:0] iord, regdst, srca, srcb, exc;
    logic [2:0] m2r, pcsrc;
    logic       rsto;
    logic [4:0] st;
  } snap_t;

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] n_pcw, n_irw, n_abw, n_brw, n_memw, n_mdrw, n_epcw;
    logic [3:0] n_hiw, n_low, n_mds, n_iord01, n_iord11, n_rst;
    logic [2:0] pcsrc_last;
    logic [1:0] exc_epc, regdst_brw;
    logic [2:0] m2r_brw;
    logic       mod_hiw;
  } sum_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic ov_v, eq_v, ed_v, done_v;
  logic [5:0] op_v, fn_v;
  int total = 0;
  int bad = 0;
  snap_t trace [0:255];

  ctrl_unit_mc_if b3 ();
  ctrl_unit_mc_if b5 ();

  assign b3.Overflow = ov_v;  assign b5.Overflow = ov_v;
  assign b3.EQ       = eq_v;  assign b5.EQ       = eq_v;
  assign b3.ErroDiv  = ed_v;  assign b5.ErroDiv  = ed_v;
  assign b3.md_done  = done_v; assign b5.md_done = done_v;
  assign b3.OPCODE   = op_v;  assign b5.OPCODE   = op_v;
  assign b3.FUNCT    = fn_v;  assign b5.FUNCT    = fn_v;

  ctrl_unit_mc #(.MEM_LAT(3), .CNT_W(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));
  ctrl_unit_mc #(.MEM_LAT(5), .CNT_W(3)) dut5 (.clk(clk), .reset(reset), .bus(b5));

  snap_t snap3, snap5;
  assign snap3 = '{pcw: b3.PCWrite, memw: b3.MemWrite, irw: b3.IRWrite, brw: b3.BRWrite,
                   abw: b3.ABWrite, epcw: b3.EPCWrite, hiw: b3.HIWrite, low: b3.LOWrite,
                   mdrw: b3.MDRWrite, aluow: b3.ALUOutWrite, mds: b3.md_start, mod: b3.MultOrDiv,
                   aluop: b3.ALUOp, iord: b3.IorD, regdst: b3.RegDst, srca: b3.ALUSrcA,
                   srcb: b3.ALUSrcB, exc: b3.Exception, m2r: b3.MemToReg, pcsrc: b3.PCSource,
                   rsto: b3.rst_out, st: b3.state_dbg};
  assign snap5 = '{pcw: b5.PCWrite, memw: b5.MemWrite, irw: b5.IRWrite, brw: b5.BRWrite,
                   abw: b5.ABWrite, epcw: b5.EPCWrite, hiw: b5.HIWrite, low: b5.LOWrite,
                   mdrw: b5.MDRWrite, aluow: b5.ALUOutWrite, mds: b5.md_start, mod: b5.MultOrDiv,
                   aluop: b5.ALUOp, iord: b5.IorD, regdst: b5.RegDst, srca: b5.ALUSrcA,
                   srcb: b5.ALUSrcB, exc: b5.Exception, m2r: b5.MemToReg, pcsrc: b5.PCSource,
                   rsto: b5.rst_out, st: b5.state_dbg};

  function automatic snap_t take(input bit sel);
    return sel ? snap5 : snap3;
  endfunction

  // Reference: what one instruction does, summarised from the ISA-level rules
  function automatic sum_t model(input logic [5:0] op, input logic [5:0] fn, input bit ov,
                                 input bit eq, input bit ed, input int mdl, input int lat);
    sum_t e = '0;
    int exc = -1;
    int pre = 0;
    e.n_pcw = 1; e.n_irw = 1; e.n_abw = 1;
    case (op)
      OP_R: begin
        if ((fn == FN_ADD || fn == FN_SUB) && ov) begin
          exc = 1; pre = lat + 3;
        end else if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND) begin
          e.cycles = 8'(lat + 4); e.n_brw = 1; e.regdst_brw = 2'b01; e.m2r_brw = 3'd0;
        end else if (fn == FN_MULT || fn == FN_DIV) begin
          e.n_mds = 1;
          if (fn == FN_DIV && ed) begin
            exc = 2; pre = lat + 3 + mdl;
          end else begin
            e.cycles = 8'(lat + 3 + mdl); e.n_hiw = 1; e.n_low = 1;
            e.mod_hiw = (fn == FN_DIV);
          end
        end else begin
          exc = 0; pre = lat + 2;
        end
      end
      OP_ADDI, OP_ADDIU: begin
        if (op == OP_ADDI && ov) begin
          exc = 1; pre = lat + 3;
        end else begin
          e.cycles = 8'(lat + 4); e.n_brw = 1; e.regdst_brw = 2'b00; e.m2r_brw = 3'd0;
        end
      end
      OP_BEQ, OP_BNE: begin
        e.cycles = 8'(lat + 3);
        if ((op == OP_BEQ) ? eq : !eq) begin
          e.n_pcw = 2; e.pcsrc_last = 3'd1;
        end
      end
      OP_J: begin
        e.cycles = 8'(lat + 3); e.n_pcw = 2; e.pcsrc_last = 3'd2;
      end
      OP_LW: begin
        e.cycles = 8'(2 * lat + 5); e.n_iord01 = 4'(lat); e.n_mdrw = 1;
        e.n_brw = 1; e.regdst_brw = 2'b00; e.m2r_brw = 3'd1;
      end
      OP_SW: begin
        e.cycles = 8'(lat + 4); e.n_iord01 = 1; e.n_memw = 1;
      end
      default: begin
        exc = 0; pre = lat + 2;
      end
    endcase
    if (exc >= 0) begin
      e.cycles = 8'(pre + lat + 3); e.n_epcw = 1; e.exc_epc = 2'(exc);
      e.n_iord11 = 4'(lat); e.n_mdrw = 1; e.n_pcw = 2; e.pcsrc_last = 3'd3;
    end
    return e;
  endfunction

  // Runs one instruction from FETCH entry (called at posedge+1 in FETCH),
  // returning at posedge+1 of the next FETCH entry.
  task automatic run_instr(input bit sel, input logic [5:0] op, input logic [5:0] fn,
                           input bit ov, input bit eq, input bit ed, input int mdl,
                           output sum_t s);
    int n = 0;
    int md_cnt = -1;
    bit left = 0;
    snap_t sn;
    s = '0;
    op_v = op; fn_v = fn; ov_v = ov; eq_v = eq;
    while (1) begin
      if (left && take(sel).st == ST_FETCH) break;
      if (n >= 200) begin
        total++; bad++;
        $display("FAIL timeout: op=%h fn=%h never returned to fetch, got %0d cycles, need < 200", op, fn, n);
        break;
      end
      done_v = (md_cnt == mdl - 1);
      ed_v = done_v ? ed : 1'($urandom_range(0, 1));
      @(negedge clk);
      sn = take(sel);
      trace[n] = sn;
      if (sn.st != ST_FETCH) left = 1;
      if (sn.pcw)  begin s.n_pcw++; s.pcsrc_last = sn.pcsrc; end
      if (sn.irw)  s.n_irw++;
      if (sn.abw)  s.n_abw++;
      if (sn.brw)  begin s.n_brw++; s.regdst_brw = sn.regdst; s.m2r_brw = sn.m2r; end
      if (sn.memw) s.n_memw++;
      if (sn.mdrw) s.n_mdrw++;
      if (sn.epcw) begin s.n_epcw++; s.exc_epc = sn.exc; end
      if (sn.hiw)  begin s.n_hiw++; s.mod_hiw = sn.mod; end
      if (sn.low)  s.n_low++;
      if (sn.mds)  s.n_mds++;
      if (sn.rsto) s.n_rst++;
      if (sn.iord == 2'b01) s.n_iord01++;
      if (sn.iord == 2'b11) s.n_iord11++;
      if (done_v) md_cnt = -1;
      else if (sn.mds) md_cnt = 0;
      else if (md_cnt >= 0) md_cnt++;
      n++;
      @(posedge clk); #1;
    end
    done_v = 0;
    s.cycles = 8'(n);
    $display("txn lat=%0d op=%h fn=%h ov=%0d eq=%0d ed=%0d mdl=%0d cycles=%0d",
             sel ? 5 : 3, op, fn, ov, eq, ed, mdl, n);
  endtask

  task automatic do_reset();
    reset = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    snap_t exp = '0;
    exp.rsto = 1; exp.st = ST_RST;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (snap3 !== exp) begin bad++; $display("FAIL reset_l3 cyc%0d: got %h need %h", i, snap3, exp); end
      total++;
      if (snap5 !== exp) begin bad++; $display("FAIL reset_l5 cyc%0d: got %h need %h", i, snap5, exp); end
    end
    reset = 1;
    @(posedge clk); #1;
    total++;
    if (snap3.st !== ST_FETCH || snap3.rsto !== 1'b0) begin
      bad++; $display("FAIL reset_release: got st=%0d rst_out=%b need st=%0d rst_out=0", snap3.st, snap3.rsto, ST_FETCH);
    end
    total++;
    if (snap5.st !== ST_FETCH || snap5.rsto !== 1'b0) begin
      bad++; $display("FAIL reset_release5: got st=%0d rst_out=%b need st=%0d rst_out=0", snap5.st, snap5.rsto, ST_FETCH);
    end
  endtask

  task automatic test_add();
    sum_t o, e;
    run_instr(0, OP_R, FN_ADD, 0, 0, 0, 1, o);
    e = model(OP_R, FN_ADD, 0, 0, 0, 1, 3);
    total++;
    if (o !== e) begin bad++; $display("FAIL add_summary: got %h need %h", o, e); end
    total++;
    if (trace[3].irw !== 1'b1) begin bad++; $display("FAIL add_irwrite_c4: got %b need 1", trace[3].irw); end
    total++;
    if (trace[4].abw !== 1'b1) begin bad++; $display("FAIL add_abwrite_c5: got %b need 1", trace[4].abw); end
    total++;
    if (trace[5].aluow !== 1'b1 || trace[5].aluop !== 3'd1) begin
      bad++; $display("FAIL add_exec_c6: got aluoutw=%b aluop=%0d need 1/1", trace[5].aluow, trace[5].aluop);
    end
    total++;
    if (trace[6].brw !== 1'b1 || trace[6].regdst !== 2'b01) begin
      bad++; $display("FAIL add_wb_c7: got brw=%b regdst=%b need 1/01", trace[6].brw, trace[6].regdst);
    end
  endtask

  task automatic test_add_overflow();
    sum_t o, e;
    run_instr(0, OP_R, FN_ADD, 1, 0, 0, 1, o);
    e = model(OP_R, FN_ADD, 1, 0, 0, 1, 3);
    total++;
    if (o !== e) begin bad++; $display("FAIL ovf_summary: got %h need %h", o, e); end
    total++;
    if (trace[6].epcw !== 1'b1 || trace[6].exc !== 2'b01) begin
      bad++; $display("FAIL ovf_epc: got epcw=%b exc=%b need 1/01", trace[6].epcw, trace[6].exc);
    end
    total++;
    if (trace[11].pcw !== 1'b1 || trace[11].pcsrc !== 3'd3) begin
      bad++; $display("FAIL ovf_vector_jump: got pcw=%b pcsrc=%0d need 1/3", trace[11].pcw, trace[11].pcsrc);
    end
  endtask

  task automatic test_branch();
    sum_t o, e;
    run_instr(0, OP_BEQ, 6'h00, 0, 1, 0, 1, o);
    e = model(OP_BEQ, 6'h00, 0, 1, 0, 1, 3);
    total++;
    if (o !== e) begin bad++; $display("FAIL beq_taken: got %h need %h", o, e); end
    total++;
    if (o.n_pcw !== 4'd2 || o.pcsrc_last !== 3'd1) begin
      bad++; $display("FAIL beq_pcwrite: got n=%0d src=%0d need 2/1", o.n_pcw, o.pcsrc_last);
    end
    run_instr(0, OP_BNE, 6'h00, 0, 1, 0, 1, o);
    e = model(OP_BNE, 6'h00, 0, 1, 0, 1, 3);
    total++;
    if (o !== e) begin bad++; $display("FAIL bne_not_taken: got %h need %h", o, e); end
    total++;
    if (o.n_pcw !== 4'd1) begin bad++; $display("FAIL bne_pcwrite: got n=%0d need 1", o.n_pcw); end
  endtask

  task automatic test_lw_lat5();
    sum_t o, e;
    do_reset();
    run_instr(1, OP_LW, 6'h00, 0, 0, 0, 1, o);
    e = model(OP_LW, 6'h00, 0, 0, 0, 1, 5);
    total++;
    if (o !== e) begin bad++; $display("FAIL lw5_summary: got %h need %h", o, e); end
    total++;
    if (o.n_iord01 !== 4'd5 || o.m2r_brw !== 3'd1) begin
      bad++; $display("FAIL lw5_mem: got iord01=%0d m2r=%0d need 5/1", o.n_iord01, o.m2r_brw);
    end
    do_reset();
  endtask

  task automatic test_md_and_illegal();
    sum_t o, e;
    run_instr(0, OP_R, FN_DIV, 0, 0, 1, 10, o);
    e = model(OP_R, FN_DIV, 0, 0, 1, 10, 3);
    total++;
    if (o !== e) begin bad++; $display("FAIL div0_summary: got %h need %h", o, e); end
    total++;
    if (o.n_mds !== 4'd1 || o.n_hiw !== 4'd0 || o.exc_epc !== 2'b10) begin
      bad++; $display("FAIL div0_detail: got mds=%0d hiw=%0d exc=%b need 1/0/10", o.n_mds, o.n_hiw, o.exc_epc);
    end
    run_instr(0, OP_R, FN_MULT, 0, 0, 1, 4, o);
    e = model(OP_R, FN_MULT, 0, 0, 1, 4, 3);
    total++;
    if (o !== e) begin bad++; $display("FAIL mult_summary: got %h need %h", o, e); end
    run_instr(0, 6'h3f, 6'h00, 0, 0, 0, 1, o);
    e = model(6'h3f, 6'h00, 0, 0, 0, 1, 3);
    total++;
    if (o !== e) begin bad++; $display("FAIL illegal_summary: got %h need %h", o, e); end
    total++;
    if (trace[5].epcw !== 1'b1 || trace[5].exc !== 2'b00) begin
      bad++; $display("FAIL illegal_epc: got epcw=%b exc=%b need 1/00", trace[5].epcw, trace[5].exc);
    end
  endtask

  task automatic test_reset_mid();
    snap_t sn;
    int brw_seen = 0;
    op_v = OP_LW; fn_v = 6'h00; ov_v = 0;
    for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sn = take(0);
      if (sn.brw || sn.mdrw) brw_seen++;
      if (i > 0) begin
        total++;
        if (sn.st !== ST_RST || sn.rsto !== 1'b1) begin
          bad++; $display("FAIL mid_reset_state c%0d: got st=%0d rst_out=%b need %0d/1", i, sn.st, sn.rsto, ST_RST);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (brw_seen != 0) begin bad++; $display("FAIL mid_reset_writeback: got %0d writes need 0", brw_seen); end
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back(input bit sel, input int count);
    sum_t o, e;
    logic [5:0] op, fn;
    bit ov, eq, ed;
    int mdl;
    for (int t = 0; t < count; t++) begin
      op = OP_R;
      fn = 6'h00;
      case ($urandom_range(0, 13))
        0: fn = FN_ADD;   1: fn = FN_SUB;  2: fn = FN_AND;
        3: fn = FN_MULT;  4: fn = FN_DIV;  5: fn = 6'($urandom_range(0, 63));
        6: op = OP_ADDI;  7: op = OP_ADDIU; 8: op = OP_BEQ; 9: op = OP_BNE;
        10: op = OP_J;    11: op = OP_LW;  12: op = OP_SW;
        default: op = 6'($urandom_range(0, 63));
      endcase
      ov = 1'($urandom_range(0, 1));
      eq = 1'($urandom_range(0, 1));
      ed = 1'($urandom_range(0, 1));
      mdl = $urandom_range(1, 6);
      run_instr(sel, op, fn, ov, eq, ed, mdl, o);
      e = model(op, fn, ov, eq, ed, mdl, sel ? 5 : 3);
      total++;
      if (o !== e) begin
        bad++; $display("FAIL b2b op=%h fn=%h ov=%0d eq=%0d ed=%0d: got %h need %h", op, fn, ov, eq, ed, o, e);
      end
    end
  endtask

  initial begin
    reset = 0; ov_v = 0; eq_v = 0; ed_v = 0; done_v = 0; op_v = 6'h00; fn_v = 6'h00;
    test_reset();
    test_add();
    test_add_overflow();
    test_branch();
    test_md_and_illegal();
    test_reset_mid();
    test_back_to_back(0, 40);
    test_lw_lat5();
    test_back_to_back(1, 40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
